// File: rtl/smd_button_debouncer.sv
// Twelve-channel debouncer for active-low pad switches. Each channel is
// synchronized, then must disagree with its debounced value on consecutive sample ticks before it updates.
module smd_button_debouncer #(
    parameter int unsigned SAMPLE_DIV     = 10000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] btn_raw,
    output logic [11:0] btn,
    output logic        valid,
    output logic        changed
);

    localparam int unsigned NB = 12;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 4;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] TICK_SAT  = CW'(DEBOUNCE_TICKS);

    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [CW-1:0] tcnt_q;
    logic [CW-1:0] tcnt_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [NB-1:0] btn_d;
    logic          valid_d;
    logic          changed_d;
    logic          tick_c;

    // Synchronizers reset to "released" so no phantom press is seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign tick_c = (presc_q == PRESC_MAX);

    // Next-state: prescaler, warm-up tick counter and per-bit debounce counters.
    always_comb begin
        presc_d   = presc_q + PW'(1);
        tcnt_d    = tcnt_q;
        btn_d     = btn;
        valid_d   = valid;
        changed_d = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (tick_c) begin
            presc_d = '0;
            if (tcnt_q != TICK_SAT) begin
                tcnt_d = tcnt_q + CW'(1);
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2_q[i] == btn[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= CNT_MAX) begin
                    btn_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        valid_d   = valid | (tcnt_d == TICK_SAT);
        changed_d = (btn_d != btn);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tcnt_q  <= '0;
            btn     <= '1;
            valid   <= 1'b0;
            changed <= 1'b0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            btn     <= btn_d;
            valid   <= valid_d;
            changed <= changed_d;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_smd_button_debouncer.sv
// Directed bench for smd_button_debouncer: one instance at SAMPLE_DIV=4/DEBOUNCE_TICKS=3,
// one at SAMPLE_DIV=2/DEBOUNCE_TICKS=1.
module tb_smd_button_debouncer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst1_n;
    logic [11:0] raw;
    logic [11:0] raw1;
    logic [11:0] btn;
    logic [11:0] btn1;
    logic        valid;
    logic        valid1;
    logic        changed;
    logic        changed1;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    smd_button_debouncer #(.SAMPLE_DIV(4), .DEBOUNCE_TICKS(3)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (raw),
        .btn     (btn),
        .valid   (valid),
        .changed (changed)
    );

    smd_button_debouncer #(.SAMPLE_DIV(2), .DEBOUNCE_TICKS(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst1_n),
        .btn_raw (raw1),
        .btn     (btn1),
        .valid   (valid1),
        .changed (changed1)
    );

    always @(negedge clk) begin
        if (rst_n && changed) pulses++;
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        raw    = 12'hFFF;
        raw1   = 12'h7FF;
        repeat (3) step();
        chk("reset_btn", btn, 12'hFFF);
        chk("reset_valid", 12'(valid), 12'h000);
        chk("reset_changed", 12'(changed), 12'h000);

        // Idle after release: valid rises on the third tick edge (edge 12).
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("idle_btn", btn, 12'hFFF);
            chk("idle_valid", 12'(valid), 12'(k >= 12));
            chk("idle_changed", 12'(changed), 12'h000);
        end

        // Bit 4 toggles every 5 cycles: never three disagreeing ticks in a row.
        for (int i = 0; i < 12; i++) begin
            raw[4] = (i % 2 == 1);
            for (int j = 0; j < 5; j++) begin
                step();
                chk("bounce_btn", btn, 12'hFFF);
                chk("bounce_changed", 12'(changed), 12'h000);
            end
        end
        raw = 12'hFFF;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("settle_btn", btn, 12'hFFF);
        end

        // Clean press on bit 4 right after a tick edge: ticks at +4,+8,+12.
        raw[4] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("press_btn", btn, (k < 12) ? 12'hFFF : 12'hFEF);
            chk("press_changed", 12'(changed), 12'(k == 12));
        end

        // Release two cycles after a tick edge: ticks at +6,+10,+14.
        raw[4] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("release_btn", btn, (k < 14) ? 12'hFEF : 12'hFFF);
            chk("release_changed", 12'(changed), 12'(k == 14));
        end

        // Bits 0 and 11 pressed together.
        raw = 12'h7FE;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("dual_btn", btn, (k < 12) ? 12'hFFF : 12'h7FE);
            chk("dual_changed", 12'(changed), 12'(k == 12));
        end

        // Partial count on bit 7 discarded by a reset pulse.
        raw = 12'hF7F;
        repeat (7) step();
        chk("prereset_btn", btn, 12'h7FE);
        rst_n = 1'b0;
        #1;
        chk("midreset_btn", btn, 12'hFFF);
        chk("midreset_valid", 12'(valid), 12'h000);
        chk("midreset_changed", 12'(changed), 12'h000);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("rerun_btn", btn, (k < 12) ? 12'hFFF : 12'hF7F);
            chk("rerun_valid", 12'(valid), 12'(k >= 12));
            chk("rerun_changed", 12'(changed), 12'(k == 12));
        end
        chk("pulse_total", 12'(pulses), 12'd4);

        // Single-tick instance: first tick edge is 2, md visible through sync at tick edge 4.
        chk("d1_reset_btn", btn1, 12'hFFF);
        rst1_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("d1_valid", 12'(valid1), 12'(k >= 2));
            chk("d1_btn", btn1, (k >= 4) ? 12'h7FF : 12'hFFF);
            chk("d1_changed", 12'(changed1), 12'(k == 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
